mem_access_stage: RTL

Memory-access stage between the EX/M pipeline register and the M/WB register. It consumes the registered EX/M bundle and runs load/store accesses to data memory over a req/ack handshake. While an access is pending it stalls the upstream register. It then presents a registered M/WB bundle, with load data, to write-back.

---
 rtl/mem_access_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory-access stage: EX/M bundle in, req/ack data-memory access, registered M/WB out.
// Optional MEM_TIMEOUT_EN aborts accesses that wait TIMEOUT_CYCLES without ack.
module mem_access_stage #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [15:0]       PC_plus1_in_M,
  input  logic [2:0]        WB_in_M,
  input  logic [1:0]        Memory_in_M,
  input  logic [15:0]       ALU_in_M,
  input  logic [15:0]       Memory_data_write_in_M,
  input  logic [15:0]       Zero_pad_in_M,
  input  logic [2:0]        Dest_in_M,
  input  logic              Valid_in_M,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  input  logic [15:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic [15:0]       PC_plus1_out_M_WB,
  output logic [2:0]        WB_out_M_WB,
  output logic [15:0]       ALU_out_M_WB,
  output logic [15:0]       Load_data_out_M_WB,
  output logic [15:0]       Zero_pad_out_M_WB,
  output logic [2:0]        Dest_out_M_WB,
  output logic              Valid_out_M_WB,
  output logic              Mem_err_out_M_WB
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state;
  logic                h_we;
  logic [ADDR_W-1:0]   h_addr;
  logic [15:0]         h_wdata;
  logic [15:0]         h_pc;
  logic [15:0]         h_alu;
  logic [15:0]         h_zp;
  logic [2:0]          h_wb;
  logic [2:0]          h_dest;
  logic                is_mem;

  assign is_mem = Memory_in_M[1] | Memory_in_M[0];

  // Handshake outputs come only from registered state.
  assign dmem_req   = (state == ACCESS);
  assign stall_out  = (state == ACCESS);
  assign dmem_we    = (state == ACCESS) & h_we;
  assign dmem_addr  = h_addr;
  assign dmem_wdata = h_wdata;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt;
  logic       expire;
  assign expire = (cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign Mem_err_out_M_WB = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      h_we               <= 1'b0;
      h_addr             <= '0;
      h_wdata            <= '0;
      h_pc               <= '0;
      h_alu              <= '0;
      h_zp               <= '0;
      h_wb               <= '0;
      h_dest             <= '0;
      PC_plus1_out_M_WB  <= '0;
      WB_out_M_WB        <= '0;
      ALU_out_M_WB       <= '0;
      Load_data_out_M_WB <= '0;
      Zero_pad_out_M_WB  <= '0;
      Dest_out_M_WB      <= '0;
      Valid_out_M_WB     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt                <= '0;
      Mem_err_out_M_WB   <= 1'b0;
`endif
    end else begin
      Valid_out_M_WB <= 1'b0;
      unique case (state)
        IDLE: begin
          if (Valid_in_M && is_mem) begin
            h_we    <= Memory_in_M[0];
            h_addr  <= ALU_in_M[ADDR_W-1:0];
            h_wdata <= Memory_data_write_in_M;
            h_pc    <= PC_plus1_in_M;
            h_alu   <= ALU_in_M;
            h_zp    <= Zero_pad_in_M;
            h_wb    <= WB_in_M;
            h_dest  <= Dest_in_M;
            state   <= ACCESS;
`ifdef MEM_TIMEOUT_EN
            cnt     <= '0;
`endif
          end else if (Valid_in_M) begin
            PC_plus1_out_M_WB  <= PC_plus1_in_M;
            WB_out_M_WB        <= WB_in_M;
            ALU_out_M_WB       <= ALU_in_M;
            Load_data_out_M_WB <= '0;
            Zero_pad_out_M_WB  <= Zero_pad_in_M;
            Dest_out_M_WB      <= Dest_in_M;
            Valid_out_M_WB     <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            Mem_err_out_M_WB   <= 1'b0;
`endif
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            PC_plus1_out_M_WB  <= h_pc;
            WB_out_M_WB        <= h_wb;
            ALU_out_M_WB       <= h_alu;
            Load_data_out_M_WB <= h_we ? 16'h0 : dmem_rdata;
            Zero_pad_out_M_WB  <= h_zp;
            Dest_out_M_WB      <= h_dest;
            Valid_out_M_WB     <= 1'b1;
            state              <= IDLE;
`ifdef MEM_TIMEOUT_EN
            Mem_err_out_M_WB   <= 1'b0;
          end else if (expire) begin
            PC_plus1_out_M_WB  <= h_pc;
            WB_out_M_WB        <= h_wb;
            ALU_out_M_WB       <= h_alu;
            Load_data_out_M_WB <= '0;
            Zero_pad_out_M_WB  <= h_zp;
            Dest_out_M_WB      <= h_dest;
            Valid_out_M_WB     <= 1'b1;
            Mem_err_out_M_WB   <= 1'b1;
            state              <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
